// File: rtl/modbus_rtu_frame_assembler.sv
// Modbus RTU frame assembler: buffers UART bytes, delimits frames on t1.5/t3.5 silence,
// drives the CRC calculator and reports one verdict per frame.
module modbus_rtu_frame_assembler #(
    parameter int unsigned T15_TICKS = 750,
    parameter int unsigned T35_TICKS = 1750,
    parameter int unsigned MAX_SIZE  = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    crc_start,
    output logic [7:0]              crc_size,
    input  logic                    crc_valid,
    input  logic [15:0]             crc_data,
    output logic [MAX_SIZE*8-1:0]   frame_data,
    output logic [8:0]              frame_len,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic [3:0]              frame_err,
    output logic                    rx_drop
);

    localparam int unsigned TimerW = $clog2(T35_TICKS + 1);

    typedef enum logic [2:0] {
        StSync,
        StIdle,
        StReceive,
        StCrcStart,
        StCrcArm,
        StCrcWait,
        StReport
    } state_e;

    state_e                state_q, state_d;
    logic [TimerW-1:0]     timer_q;
    logic [8:0]            frame_len_q, frame_len_d;
    logic [3:0]            err_q, err_d;
    logic                  drop_q, drop_d;
    logic [7:0]            crc_size_q, crc_size_d;
    logic [MAX_SIZE*8-1:0] frame_data_q;
    logic                  wr_en;
    logic [7:0]            wr_idx;
    logic [8:0]            size_full;
    logic [7:0]            hi_idx, lo_idx;
    logic [15:0]           rx_crc;
    logic                  short_frame;
    logic                  timer_t35;
    logic                  timer_in_t15;
    logic                  busy;

    assign timer_t35    = (timer_q == TimerW'(T35_TICKS));
    assign timer_in_t15 = (timer_q < TimerW'(T15_TICKS));
    assign short_frame  = (frame_len_q < 9'd4);
    assign size_full    = frame_len_q - 9'd2;

    // CRC travels low byte first, so the last stored byte is the high half.
    assign hi_idx = frame_len_q[7:0] - 8'd1;
    assign lo_idx = frame_len_q[7:0] - 8'd2;
    assign rx_crc = {frame_data_q[{hi_idx, 3'b000} +: 8], frame_data_q[{lo_idx, 3'b000} +: 8]};

    assign busy = (state_q == StCrcStart) || (state_q == StCrcArm) ||
                  (state_q == StCrcWait) || (state_q == StReport);

    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        err_d       = err_q;
        drop_d      = drop_q;
        crc_size_d  = crc_size_q;
        wr_en       = 1'b0;
        wr_idx      = frame_len_q[7:0];
        crc_start   = 1'b0;
        frame_done  = 1'b0;
        frame_ok    = 1'b0;
        frame_err   = 4'd0;
        rx_drop     = rx_valid & busy;

        case (state_q)
            StSync: begin
                if (timer_t35) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (rx_valid) begin
                    wr_en       = 1'b1;
                    wr_idx      = 8'd0;
                    frame_len_d = 9'd1;
                    err_d       = 4'd0;
                    drop_d      = 1'b0;
                    state_d     = StReceive;
                end
            end
            StReceive: begin
                if (rx_valid) begin
                    if (!timer_in_t15) begin
                        err_d[0] = 1'b1;
                    end else if (frame_len_q == 9'(MAX_SIZE)) begin
                        err_d[1] = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        frame_len_d = frame_len_q + 9'd1;
                    end
                end else if (timer_t35) begin
                    if ((err_q[1:0] != 2'b00) || short_frame) begin
                        err_d[2] = err_q[2] | short_frame;
                        state_d  = StReport;
                    end else begin
                        crc_size_d = size_full[7:0];
                        state_d    = StCrcStart;
                    end
                end
            end
            StCrcStart: begin
                crc_start = 1'b1;
                drop_d    = drop_q | rx_valid;
                state_d   = StCrcArm;
            end
            StCrcArm: begin
                drop_d = drop_q | rx_valid;
                if (!crc_valid) begin
                    state_d = StCrcWait;
                end
            end
            StCrcWait: begin
                drop_d = drop_q | rx_valid;
                if (crc_valid) begin
                    if (crc_data != rx_crc) begin
                        err_d[3] = 1'b1;
                    end
                    state_d = StReport;
                end
            end
            StReport: begin
                frame_done = 1'b1;
                frame_ok   = (err_q == 4'd0);
                frame_err  = err_q;
                drop_d     = 1'b0;
                // A dropped byte means the line state is unknown: resynchronise.
                state_d    = (drop_q || rx_valid) ? StSync : StIdle;
            end
            default: begin
                state_d = StSync;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StSync;
            timer_q     <= '0;
            frame_len_q <= 9'd0;
            err_q       <= 4'd0;
            drop_q      <= 1'b0;
            crc_size_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            err_q       <= err_d;
            drop_q      <= drop_d;
            crc_size_q  <= crc_size_d;
            if (rx_valid) begin
                timer_q <= '0;
            end else if (!timer_t35) begin
                timer_q <= timer_q + TimerW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_data_q <= '0;
        end else if (wr_en) begin
            frame_data_q[{wr_idx, 3'b000} +: 8] <= rx_data;
        end
    end

    assign frame_data = frame_data_q;
    assign frame_len  = frame_len_q;
    assign crc_size   = crc_size_q;

endmodule
